// File: rtl/fp_rf_arb_pkg.sv
// Shared types and default constants for the FP register-file port arbiter.
//   wr_entry_t  : one buffered photon write {addr, data} at the default widths
//   arb_state_t : write-port arbitration state (NORMAL / FORCE)
//   *_DEF       : default parameter values used by the arbiter and its queue
package fp_rf_arb_pkg;

  localparam int QDEPTH_DEF     = 2;
  localparam int STARVE_MAX_DEF = 4;
  localparam int AW_DEF         = 5;
  localparam int DW_DEF         = 32;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wr_entry_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fp_rf_wq.sv
// Photon write queue: a small FIFO of {addr, data} entries.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset (empties the queue)
//   push_i, push_addr/data_i   enqueue request (ignored while full)
//   pop_i                      dequeue the head (ignored while empty)
//   match_addr_i               address compared against every occupied entry
//   full_o, empty_o            occupancy flags
//   head_addr_o, head_data_o   oldest entry
//   match_o                    per-entry "occupied and addr == match_addr_i"
module fp_rf_wq
  import fp_rf_arb_pkg::*;
#(
  parameter int DEPTH = QDEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [AW-1:0]    push_addr_i,
  input  logic [DW-1:0]    push_data_i,
  input  logic             pop_i,
  input  logic [AW-1:0]    match_addr_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW-1:0]    head_addr_o,
  output logic [DW-1:0]    head_data_o,
  output logic [DEPTH-1:0] match_o
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr_q] <= push_addr_i;
      data_mem[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_addr_o = addr_mem[rd_ptr_q];
  assign head_data_o = data_mem[rd_ptr_q];

  // Slot i is occupied when its distance from the read pointer (mod DEPTH,
  // DEPTH being a power of two) is below the current count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic [PW-1:0] off;
    assign off        = PW'(i) - rd_ptr_q;
    assign match_o[i] = ({1'b0, off} < count_q) && (addr_mem[i] == match_addr_i);
  end

endmodule

// File: rtl/fp_regfile_port_arbiter.sv
// Arbitrates the FP register file's single write port and shared rs1 read
// port between the pipeline WB stage (priority) and the photon coprocessor.
// Photon writes are queued; after STARVE_MAX consecutive write cycles lost to
// the pipeline with a non-empty queue, one FORCE cycle stalls the pipeline
// and drains the queue head. Photon reads return data one cycle after accept
// and see a same-cycle write through a bypass.
//
// Handshakes: a transfer happens on a cycle where valid && ready are both
// high; ready never depends on a transfer completing in the same cycle
// (ph_wr_ready is !full, with no pass-through when full).
//
// Ports:
//   clk, Rst                       clock, asynchronous active-low reset
//   wb_regwrite/wb_rd/wb_data      pipeline write-back request
//   mem_hold                       suppresses the pipeline write
//   pipe_stall                     pipeline must hold WB (forced photon slot)
//   ph_wr_valid/ready/addr/data    photon write request into the queue
//   pipe_rs1, pipe_rs1_data        pipeline rs1 read (address 0 = no read)
//   ph_rd_valid/addr/ready         photon read request
//   ph_rd_data_valid, ph_rd_data   photon read result, one cycle after accept
//   rf_we/rf_waddr/rf_wdata        register-file write port
//   rf_raddr, rf_rdata             register-file shared read port
module fp_regfile_port_arbiter
  import fp_rf_arb_pkg::*;
#(
  parameter int QDEPTH     = QDEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          wb_regwrite,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic          mem_hold,
  output logic          pipe_stall,
  input  logic          ph_wr_valid,
  output logic          ph_wr_ready,
  input  logic [AW-1:0] ph_wr_addr,
  input  logic [DW-1:0] ph_wr_data,
  input  logic [AW-1:0] pipe_rs1,
  output logic [DW-1:0] pipe_rs1_data,
  input  logic          ph_rd_valid,
  input  logic [AW-1:0] ph_rd_addr,
  output logic          ph_rd_ready,
  output logic          ph_rd_data_valid,
  output logic [DW-1:0] ph_rd_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [AW-1:0] rf_raddr,
  input  logic [DW-1:0] rf_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          rd_valid_q;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic              pw, q_push, q_pop, q_full, q_empty, hazard, rd_accept;
  logic [AW-1:0]     q_head_addr;
  logic [DW-1:0]     q_head_data;
  logic [QDEPTH-1:0] q_match;

  logic          wr_pipe, stall, we;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata;

  assign pw     = wb_regwrite && (wb_rd != '0) && !mem_hold;
  assign q_push = ph_wr_valid && ph_wr_ready;

  fp_rf_wq #(
    .DEPTH (QDEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_wq (
    .clk          (clk),
    .rst_n        (Rst),
    .push_i       (q_push),
    .push_addr_i  (ph_wr_addr),
    .push_data_i  (ph_wr_data),
    .pop_i        (q_pop),
    .match_addr_i (ph_rd_addr),
    .full_o       (q_full),
    .empty_o      (q_empty),
    .head_addr_o  (q_head_addr),
    .head_data_o  (q_head_data),
    .match_o      (q_match)
  );

  // Write-port arbitration.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    q_pop    = 1'b0;
    stall    = 1'b0;
    wr_pipe  = 1'b0;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    case (state_q)
      NORMAL: begin
        if (pw) begin
          wr_pipe = 1'b1;
          if (!q_empty) starve_d = starve_q + CW'(1);
          if (starve_d == CW'(STARVE_MAX)) state_d = FORCE;
        end else if (!q_empty) begin
          q_pop    = 1'b1;
          starve_d = '0;
        end
      end
      FORCE: begin
        state_d  = NORMAL;
        starve_d = '0;
        if (!q_empty) begin
          stall = 1'b1;
          q_pop = 1'b1;
        end
      end
      default: state_d = NORMAL;
    endcase
    // A queued entry aimed at r0 is retired without touching the file.
    if (wr_pipe) begin
      we    = 1'b1;
      waddr = wb_rd;
      wdata = wb_data;
    end else if (q_pop && (q_head_addr != '0)) begin
      we    = 1'b1;
      waddr = q_head_addr;
      wdata = q_head_data;
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Read port. A photon read waits while any queued write targets its
  // address so it never observes a stale value.
  assign raddr     = (pipe_rs1 != '0) ? pipe_rs1 : ph_rd_addr;
  assign hazard    = |q_match;
  assign rd_accept = Rst && ph_rd_valid && (pipe_rs1 == '0) && !hazard;

  always_comb begin
    rd_data_d = rf_rdata;
    if (ph_rd_addr == '0)                    rd_data_d = '0;
    else if (we && (waddr == ph_rd_addr))    rd_data_d = wdata;
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) rd_data_q <= rd_data_d;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign pipe_stall       = Rst && stall;
  assign ph_wr_ready      = Rst && !q_full;
  assign ph_rd_ready      = rd_accept;
  assign ph_rd_data_valid = rd_valid_q;
  assign ph_rd_data       = rd_data_q;
  assign rf_we            = Rst && we;
  assign rf_waddr         = Rst ? waddr : '0;
  assign rf_wdata         = Rst ? wdata : '0;
  assign rf_raddr         = Rst ? raddr : '0;
  assign pipe_rs1_data    = (Rst && (pipe_rs1 != '0)) ? rf_rdata : '0;

endmodule

// File: tb/tb_fp_regfile_port_arbiter.sv
module tb_fp_regfile_port_arbiter;
  import fp_rf_arb_pkg::*;

  localparam int QDEPTH     = 2;
  localparam int STARVE_MAX = 4;
  localparam int AW         = 5;
  localparam int DW         = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          wb_regwrite, mem_hold, ph_wr_valid, ph_rd_valid;
  logic [AW-1:0] wb_rd, ph_wr_addr, pipe_rs1, ph_rd_addr;
  logic [DW-1:0] wb_data, ph_wr_data, rf_rdata;
  logic          pipe_stall, ph_wr_ready, ph_rd_ready, ph_rd_data_valid, rf_we;
  logic [AW-1:0] rf_waddr, rf_raddr;
  logic [DW-1:0] pipe_rs1_data, ph_rd_data, rf_wdata;

  fp_regfile_port_arbiter #(
    .QDEPTH(QDEPTH), .STARVE_MAX(STARVE_MAX), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .Rst(rst_n),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_hold(mem_hold), .pipe_stall(pipe_stall),
    .ph_wr_valid(ph_wr_valid), .ph_wr_ready(ph_wr_ready),
    .ph_wr_addr(ph_wr_addr), .ph_wr_data(ph_wr_data),
    .pipe_rs1(pipe_rs1), .pipe_rs1_data(pipe_rs1_data),
    .ph_rd_valid(ph_rd_valid), .ph_rd_addr(ph_rd_addr), .ph_rd_ready(ph_rd_ready),
    .ph_rd_data_valid(ph_rd_data_valid), .ph_rd_data(ph_rd_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
  );

  // Register file the arbiter is attached to.
  logic [DW-1:0] regs [32] = '{default: '0};
  assign rf_rdata = regs[rf_raddr];
  always @(posedge clk) if (rf_we) regs[rf_waddr] <= rf_wdata;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  wr_entry_t     mq[$];
  int            m_starve;
  bit            m_force;
  bit            m_rd_valid;
  logic [DW-1:0] m_rd_data;
  logic [DW-1:0] m_regs [32];

  logic          e_stall, e_we, e_wr_ready, e_rd_ready, e_rd_valid, e_pop;
  logic [AW-1:0] e_waddr, e_raddr;
  logic [DW-1:0] e_wdata, e_rs1d, e_rd_data;

  task automatic model_reset();
    mq.delete();
    m_starve   = 0;
    m_force    = 0;
    m_rd_valid = 0;
    m_rd_data  = '0;
  endtask

  task automatic model_eval();
    bit pw, haz;
    e_stall = 0; e_we = 0; e_wr_ready = 0; e_rd_ready = 0; e_pop = 0;
    e_waddr = '0; e_raddr = '0; e_wdata = '0; e_rs1d = '0;
    e_rd_valid = m_rd_valid;
    e_rd_data  = m_rd_data;
    if (!rst_n) begin
      e_rd_valid = 0;
      e_rd_data  = '0;
      return;
    end
    pw = wb_regwrite && (wb_rd != 0) && !mem_hold;
    e_wr_ready = (mq.size() < QDEPTH);
    if (m_force) begin
      if (mq.size() > 0) begin
        e_stall = 1;
        e_pop   = 1;
      end
    end else if (pw) begin
      e_we = 1; e_waddr = wb_rd; e_wdata = wb_data;
    end else if (mq.size() > 0) begin
      e_pop = 1;
    end
    if (e_pop && mq[0].addr != 0) begin
      e_we = 1; e_waddr = mq[0].addr; e_wdata = mq[0].data;
    end
    e_raddr = (pipe_rs1 != 0) ? pipe_rs1 : ph_rd_addr;
    e_rs1d  = (pipe_rs1 != 0) ? m_regs[pipe_rs1] : '0;
    haz = 0;
    foreach (mq[i]) if (mq[i].addr == ph_rd_addr) haz = 1;
    e_rd_ready = ph_rd_valid && (pipe_rs1 == 0) && !haz;
  endtask

  // Advance the model across one rising edge with the inputs of that cycle.
  task automatic model_update();
    bit pw, nonempty, full;
    wr_entry_t ent;
    model_eval();
    if (!rst_n) begin
      model_reset();
      return;
    end
    pw       = wb_regwrite && (wb_rd != 0) && !mem_hold;
    nonempty = (mq.size() > 0);
    full     = (mq.size() == QDEPTH);
    if (e_rd_ready) begin
      m_rd_valid = 1;
      if (ph_rd_addr == 0)                      m_rd_data = '0;
      else if (e_we && e_waddr == ph_rd_addr)   m_rd_data = e_wdata;
      else                                      m_rd_data = m_regs[ph_rd_addr];
    end else begin
      m_rd_valid = 0;
    end
    if (e_we) m_regs[e_waddr] = e_wdata;
    if (m_force) begin
      m_force  = 0;
      m_starve = 0;
    end else if (pw) begin
      if (nonempty) m_starve++;
      if (m_starve == STARVE_MAX) m_force = 1;
    end else if (nonempty) begin
      m_starve = 0;
    end
    if (e_pop) void'(mq.pop_front());
    if (ph_wr_valid && !full) begin
      ent.addr = ph_wr_addr;
      ent.data = ph_wr_data;
      mq.push_back(ent);
    end
  endtask

  task automatic check_all();
    model_eval();
    chk("stall",    32'(pipe_stall),       32'(e_stall));
    chk("we",       32'(rf_we),            32'(e_we));
    chk("waddr",    32'(rf_waddr),         32'(e_waddr));
    chk("wdata",    rf_wdata,              e_wdata);
    chk("raddr",    32'(rf_raddr),         32'(e_raddr));
    chk("rs1_data", pipe_rs1_data,         e_rs1d);
    chk("wr_ready", 32'(ph_wr_ready),      32'(e_wr_ready));
    chk("rd_ready", 32'(ph_rd_ready),      32'(e_rd_ready));
    chk("rd_valid", 32'(ph_rd_data_valid), 32'(e_rd_valid));
    chk("rd_data",  ph_rd_data,            e_rd_data);
  endtask

  // ---------------- driver tasks ----------------
  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic idle_inputs();
    wb_regwrite = 0; wb_rd = '0; wb_data = '0; mem_hold = 0;
    ph_wr_valid = 0; ph_wr_addr = '0; ph_wr_data = '0;
    pipe_rs1 = '0; ph_rd_valid = 0; ph_rd_addr = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    foreach (m_regs[i]) m_regs[i] = '0;
    model_reset();
    idle_inputs();
    #1 rst_n = 0;
    #1;
    chk("rst_we",       32'(rf_we),       0);
    chk("rst_wr_ready", 32'(ph_wr_ready), 0);
    chk("rst_stall",    32'(pipe_stall),  0);
    tick();
    step();
    chk("rst_rd_valid", 32'(ph_rd_data_valid), 0);
    chk("rst_rd_data",  ph_rd_data, 0);
    rst_n = 1;

    // Single photon write lands one cycle after enqueue.
    ph_wr_valid = 1; ph_wr_addr = 5; ph_wr_data = 32'hDEAD_BEEF;
    settle();
    chk("t1_wr_ready", 32'(ph_wr_ready), 1);
    chk("t1_no_we",    32'(rf_we), 0);
    tick();
    ph_wr_valid = 0;
    settle();
    chk("t1_we",    32'(rf_we), 1);
    chk("t1_waddr", 32'(rf_waddr), 5);
    chk("t1_wdata", rf_wdata, 32'hDEAD_BEEF);
    chk("t1_ready", 32'(ph_wr_ready), 1);
    tick();

    // Starvation: continuous pipeline writes to r3, one queued write to r7.
    wb_regwrite = 1; wb_rd = 3; wb_data = $urandom;
    ph_wr_valid = 1; ph_wr_addr = 7; ph_wr_data = 32'h7777_0007;
    settle();
    chk("t2_first_waddr", 32'(rf_waddr), 3);
    tick();
    ph_wr_valid = 0;
    for (int c = 1; c <= 4; c++) begin
      wb_data = $urandom;
      settle();
      chk("t2_pipe_waddr", 32'(rf_waddr), 3);
      chk("t2_no_stall",   32'(pipe_stall), 0);
      tick();
    end
    settle();
    chk("t2_force_stall", 32'(pipe_stall), 1);
    chk("t2_force_waddr", 32'(rf_waddr), 7);
    chk("t2_force_wdata", rf_wdata, 32'h7777_0007);
    tick();
    settle();
    chk("t2_resume_waddr", 32'(rf_waddr), 3);
    chk("t2_resume_stall", 32'(pipe_stall), 0);
    tick();
    wb_regwrite = 0;

    // mem_hold suppresses the pipeline write; the queued entry goes instead.
    mem_hold = 1; wb_regwrite = 1; wb_rd = 4;
    ph_wr_valid = 1; ph_wr_addr = 8; ph_wr_data = 32'h8888_0008;
    settle();
    chk("t3_idle_we", 32'(rf_we), 0);
    tick();
    ph_wr_valid = 0;
    settle();
    chk("t3_we",    32'(rf_we), 1);
    chk("t3_waddr", 32'(rf_waddr), 8);
    chk("t3_stall", 32'(pipe_stall), 0);
    tick();
    mem_hold = 0;

    // Fill the queue while the pipeline owns the write port.
    wb_regwrite = 1; wb_rd = 2;
    ph_wr_valid = 1; ph_wr_addr = 10; ph_wr_data = 32'hA0A0_000A;
    step();
    ph_wr_addr = 11; ph_wr_data = 32'hB0B0_000B;
    settle();
    chk("t4_second_ready", 32'(ph_wr_ready), 1);
    tick();
    ph_wr_addr = 12; ph_wr_data = 32'hC0C0_000C;
    for (int c = 2; c <= 4; c++) begin
      settle();
      chk("t4_full_ready", 32'(ph_wr_ready), 0);
      tick();
    end
    settle();
    chk("t4_force_ready", 32'(ph_wr_ready), 0);
    chk("t4_force_waddr", 32'(rf_waddr), 10);
    tick();
    settle();
    chk("t4_accept_ready", 32'(ph_wr_ready), 1);
    tick();
    ph_wr_valid = 0; wb_regwrite = 0;
    repeat (3) step();

    // Photon read of r9 held off by a queued write to r9, then bypass.
    wb_regwrite = 1; wb_rd = 3; wb_data = $urandom;
    ph_wr_valid = 1; ph_wr_addr = 9; ph_wr_data = 32'h9999_0009;
    step();
    ph_wr_valid = 0; ph_rd_valid = 1; ph_rd_addr = 9;
    for (int c = 1; c <= 4; c++) begin
      settle();
      chk("t5_rd_blocked", 32'(ph_rd_ready), 0);
      tick();
    end
    settle();
    chk("t5_force_blocked", 32'(ph_rd_ready), 0);
    chk("t5_force_waddr",   32'(rf_waddr), 9);
    tick();
    wb_rd = 9; wb_data = 32'h0000_1234;
    settle();
    chk("t5_rd_ready", 32'(ph_rd_ready), 1);
    tick();
    ph_rd_valid = 0; wb_regwrite = 0;
    settle();
    chk("t5_rd_valid", 32'(ph_rd_data_valid), 1);
    chk("t5_rd_data",  ph_rd_data, 32'h0000_1234);
    tick();
    settle();
    chk("t5_rd_valid_drop", 32'(ph_rd_data_valid), 0);
    chk("t5_rd_data_hold",  ph_rd_data, 32'h0000_1234);
    tick();
    ph_rd_valid = 1; ph_rd_addr = 0;
    step();
    ph_rd_valid = 0;
    settle();
    chk("t5_r0_data", ph_rd_data, 0);
    tick();

    // Reset asserted in the middle of a FORCE cycle with two entries queued.
    wb_regwrite = 1; wb_rd = 3;
    ph_wr_valid = 1; ph_wr_addr = 13; ph_wr_data = 32'hD0D0_000D;
    step();
    ph_wr_addr = 14; ph_wr_data = 32'hE0E0_000E;
    step();
    ph_wr_valid = 0;
    repeat (3) step();
    settle();
    chk("t6_force_stall", 32'(pipe_stall), 1);
    rst_n = 0;
    #1;
    chk("t6_rst_stall",    32'(pipe_stall), 0);
    chk("t6_rst_we",       32'(rf_we), 0);
    chk("t6_rst_waddr",    32'(rf_waddr), 0);
    chk("t6_rst_raddr",    32'(rf_raddr), 0);
    chk("t6_rst_wr_ready", 32'(ph_wr_ready), 0);
    chk("t6_rst_rd_valid", 32'(ph_rd_data_valid), 0);
    model_reset();
    tick();
    step();
    idle_inputs();
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("t6_no_we",    32'(rf_we), 0);
      chk("t6_wr_ready", 32'(ph_wr_ready), 1);
      tick();
    end

    // Randomized traffic against the model, with one reset pulse.
    for (int c = 0; c < 600; c++) begin
      if (c == 300) rst_n = 0;
      if (c == 302) rst_n = 1;
      wb_regwrite = ($urandom_range(0, 2) != 0);
      wb_rd       = AW'($urandom_range(0, 7));
      wb_data     = $urandom;
      mem_hold    = ($urandom_range(0, 4) == 0);
      ph_wr_valid = $urandom_range(0, 1) == 1;
      ph_wr_addr  = AW'($urandom_range(0, 7));
      ph_wr_data  = $urandom;
      pipe_rs1    = ($urandom_range(0, 1) == 1) ? AW'(0) : AW'($urandom_range(0, 7));
      ph_rd_valid = $urandom_range(0, 1) == 1;
      ph_rd_addr  = AW'($urandom_range(0, 7));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_regfile_port_arbiter.md
Name: fp_regfile_port_arbiter

Overview:
Shares the floating-point register file's single write port and its shared rs1 read port between the pipeline (WB stage) and the photon coprocessor. Pipeline traffic has priority on both ports. Photon writes are buffered in a small queue, and a starvation guard forces the queue to drain. Photon reads use a valid/ready handshake and return data one cycle later, with write bypass.

Parameters:
QDEPTH, 2, photon write queue depth (power of 2, at least 2)
STARVE_MAX, 4, consecutive lost write cycles with a non-empty queue before photon is forced
AW, 5, register address width
DW, 32, register data width

Ports:
clk  in  1  clock
Rst  in  1  asynchronous active-low reset
wb_regwrite  in  1  pipeline MEM_WB register-write enable
wb_rd  in  AW  pipeline destination register
wb_data  in  DW  pipeline write-back result
mem_hold  in  1  memory hold; suppresses the pipeline write
pipe_stall  out  1  pipeline must hold WB this cycle (forced photon slot)
ph_wr_valid  in  1  photon write request
ph_wr_ready  out  1  queue can accept
ph_wr_addr  in  AW  photon destination register
ph_wr_data  in  DW  photon write data
pipe_rs1  in  AW  pipeline rs1 read address (0 = no read)
pipe_rs1_data  out  DW  pipeline rs1 data (combinational from rf_rdata; 0 if pipe_rs1 == 0)
ph_rd_valid  in  1  photon read request
ph_rd_addr  in  AW  photon read address
ph_rd_ready  out  1  photon read accepted this cycle
ph_rd_data_valid  out  1  photon read data valid
ph_rd_data  out  DW  photon read data
rf_we  out  1  register-file write enable
rf_waddr  out  AW  register-file write address
rf_wdata  out  DW  register-file write data
rf_raddr  out  AW  register-file shared read address
rf_rdata  in  DW  register-file read data (combinational)

Behaviour:
- Reset (Rst = 0, asynchronous):
  - Queue emptied; starve counter = 0; forced flag = 0.
  - ph_rd_data_valid = 0 and ph_rd_data = 0.
  - All rf_* outputs = 0, pipe_stall = 0, ph_rd_ready = 0.
  - ph_wr_ready = 1 once reset is released.
  - Reset mid-operation discards queued writes.
- Pipeline write request: pw = wb_regwrite && wb_rd != 0 && !mem_hold.
- Queue:
  - FIFO of {addr, data}. Enqueue when ph_wr_valid && ph_wr_ready.
  - ph_wr_ready = !full, with no same-cycle pass-through when full.
  - An entry with addr 0 is dequeued without asserting rf_we.
- Write-port state machine:
  - NORMAL:
    - If pw, the pipeline writes. If the queue is also non-empty, starve counter += 1.
    - Else if the queue is non-empty, the head dequeues and writes; counter = 0.
    - If the counter reaches STARVE_MAX, go to FORCE.
  - FORCE (exactly 1 cycle):
    - pipe_stall = 1 (combinational from state).
    - The head dequeues and writes regardless of pw; the pipeline write is not performed.
    - counter = 0, then return to NORMAL.
    - If the queue is empty on entry to FORCE, pipe_stall = 0 and the state returns to NORMAL with no write.
- Simultaneous enqueue and dequeue is allowed when not full.
- Read port:
  - rf_raddr = pipe_rs1 if pipe_rs1 != 0; else ph_rd_addr.
  - ph_rd_ready = ph_rd_valid && pipe_rs1 == 0 && no queued entry has addr == ph_rd_addr. This enforces read-after-write ordering; the photon waits until the write drains.
  - On accept, the captured value is rf_wdata if rf_we && rf_waddr == ph_rd_addr in the same cycle, else rf_rdata.
  - ph_rd_data_valid pulses in the next cycle; ph_rd_data holds that value until the next accept.
  - ph_rd_addr == 0 returns 0.
- Latency:
  - Pipeline write: 0 added cycles.
  - Photon write: at least 1 cycle (enqueue, then dequeue).
  - Photon read: 1 cycle after accept.

Decomposition:
- fp_rf_arb_pkg: wr_entry_t {addr, data}; arb_state_t {NORMAL, FORCE}; default constants for QDEPTH and STARVE_MAX.
- One sub-module: fp_rf_wq, a parameterised FIFO with full/empty flags and a per-entry address-match output (match vector ORed for the hazard check).

Test Plan:
- Reset, then single photon write {r5, 0xDEAD_BEEF} with no pipeline traffic -> rf_we = 1, rf_waddr = 5 exactly 1 cycle after enqueue; ph_wr_ready returns to 1.
- Continuous pw (wb_rd = 3) plus one queued photon write to r7 -> 4 pipeline writes, then a FORCE cycle with pipe_stall = 1 and rf_waddr = 7, then pipeline writes resume.
- mem_hold = 1 with wb_regwrite = 1 and a queued entry -> the photon entry writes that cycle; no pipeline write; counter stays 0.
- Fill the queue with 2 entries while pw is held high -> ph_wr_ready = 0; a valid third request is not accepted until a dequeue occurs.
- Photon read of r9 while a queued write to r9 is pending -> ph_rd_ready = 0 until drained. Then read with a same-cycle pipeline write r9 = 0x1234 -> ph_rd_data = 0x1234 with ph_rd_data_valid one cycle later.
- Assert Rst low mid-FORCE with 2 entries queued -> all outputs 0 immediately, queue empty; after release no rf_we occurs.
